// File: rtl/hazard_pkg.sv
// Shared constants for the forwarding / interlock scoreboard and for decode.
package hazard_pkg;
  // Forward select value meaning "read the register file".
  localparam int FWD_RF   = 0;

  // Producer latency codes that decode drives onto id_lat.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  // Default slot record field widths (register index, latency counter).
  localparam int REG_AW   = 5;
  localparam int LAT_BITS = 2;
endpackage

// File: rtl/fwd_match.sv
// Priority search of the post-EX producer slots for one register index.
// Returns the youngest (lowest-numbered) slot that will write idx.
module fwd_match #(
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int LAT_W = 2,
  parameter int SW    = $clog2(DEPTH+1)
) (
  input  logic [AW-1:0]                 idx,
  input  logic [DEPTH-1:0]              slotVld,
  input  logic [DEPTH-1:0]              slotRegw,
  input  logic [DEPTH-1:0][AW-1:0]      slotRd,
  input  logic [DEPTH-1:0][LAT_W-1:0]   slotCnt,
  output logic                          hit,
  output logic [SW-1:0]                 slot,
  output logic [LAT_W-1:0]              cnt
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    cnt  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (slotVld[k] && slotRegw[k] && slotRd[k] == idx && idx != '0) begin
        hit  = 1'b1;
        slot = SW'(k+1);
        cnt  = slotCnt[k];
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and interlock scoreboard: tracks in-flight writes in EX plus
// DEPTH post-EX slots, drives EX bypass selects and the ID load-use stall.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int AW      = REG_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int LAT_W   = LAT_BITS,
  parameter int SW      = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [NUM_SRC*AW-1:0]   id_rs,
  input  logic [AW-1:0]           id_rd,
  input  logic                    id_regw,
  input  logic [LAT_W-1:0]        id_lat,
  output logic                    stall,
  output logic [NUM_SRC*SW-1:0]   ex_fwd_sel
);

  // EX entry
  logic                         exVld;
  logic                         exRegw;
  logic [NUM_SRC-1:0][AW-1:0]   exRs;
  logic [AW-1:0]                exRd;
  logic [LAT_W-1:0]             exLat;

  // Post-EX slots; index k holds slot k+1
  logic [DEPTH-1:0]             slotVld;
  logic [DEPTH-1:0]             slotRegw;
  logic [DEPTH-1:0][AW-1:0]     slotRd;
  logic [DEPTH-1:0][LAT_W-1:0]  slotCnt;

  logic [NUM_SRC-1:0][AW-1:0]   idRs;
  assign idRs = id_rs;

  // Per-operand search results: f* for the EX operands, s* for the ID operands.
  logic [NUM_SRC-1:0]             fHit, sHit;
  logic [NUM_SRC-1:0][SW-1:0]     fSlot, unusedSlot;
  logic [NUM_SRC-1:0][LAT_W-1:0]  fCnt, sCnt;

  for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
    fwd_match #(.AW(AW), .DEPTH(DEPTH), .LAT_W(LAT_W), .SW(SW)) uFwd (
      .idx(exRs[s]), .slotVld(slotVld), .slotRegw(slotRegw), .slotRd(slotRd),
      .slotCnt(slotCnt), .hit(fHit[s]), .slot(fSlot[s]), .cnt(fCnt[s])
    );
    fwd_match #(.AW(AW), .DEPTH(DEPTH), .LAT_W(LAT_W), .SW(SW)) uStl (
      .idx(idRs[s]), .slotVld(slotVld), .slotRegw(slotRegw), .slotRd(slotRd),
      .slotCnt(slotCnt), .hit(sHit[s]), .slot(unusedSlot[s]), .cnt(sCnt[s])
    );
    // A ready producer always has cnt==0 here; the stall guarantees it.
    assign ex_fwd_sel[s*SW +: SW] =
      (exVld && fHit[s] && fCnt[s] == '0) ? fSlot[s] : SW'(FWD_RF);
  end

  // Stall when the youngest producer of any ID source is not ready in time.
  always_comb begin
    stall = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_valid && idRs[s] != '0) begin
        if (exVld && exRegw && exRd == idRs[s]) begin
          if (exLat != '0) stall = 1'b1;
        end else if (sHit[s] && sCnt[s] > LAT_W'(1)) begin
          stall = 1'b1;
        end
      end
    end
  end

  // Pipeline advance: EX -> slot 1 -> ... -> slot DEPTH, counters saturate at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      exVld    <= 1'b0;
      exRegw   <= 1'b0;
      exRs     <= '0;
      exRd     <= '0;
      exLat    <= '0;
      slotVld  <= '0;
      slotRegw <= '0;
      slotRd   <= '0;
      slotCnt  <= '0;
    end else if (!hold) begin
      slotVld[0]  <= exVld;
      slotRegw[0] <= exRegw;
      slotRd[0]   <= exRd;
      slotCnt[0]  <= exLat;
      for (int k = 1; k < DEPTH; k++) begin
        slotVld[k]  <= slotVld[k-1];
        slotRegw[k] <= slotRegw[k-1];
        slotRd[k]   <= slotRd[k-1];
        slotCnt[k]  <= (slotCnt[k-1] != '0) ? slotCnt[k-1] - LAT_W'(1) : '0;
      end
      exVld  <= id_valid && !flush && !stall;
      exRegw <= id_regw;
      exRs   <= idRs;
      exRd   <= id_rd;
      exLat  <= id_lat;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: position-based reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_forward_hazard_unit;
  localparam int AW = 5, NUM_SRC = 2, DEPTH = 3, LAT_W = 2;
  localparam int SW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst, hold, flush, id_valid, id_regw;
  logic [NUM_SRC*AW-1:0] id_rs;
  logic [AW-1:0]         id_rd;
  logic [LAT_W-1:0]      id_lat;
  logic                  stall;
  logic [NUM_SRC*SW-1:0] ex_fwd_sel;

  int passed = 0, total = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  forward_hazard_unit #(.AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LAT_W(LAT_W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rd(id_rd), .id_regw(id_regw), .id_lat(id_lat),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel)
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: position 0 = EX, p = slot p. A producer with latency lat is
  // forwardable from position lat+1 on; a consumer stalls while lat > p.
  int mVld[0:DEPTH], mRd[0:DEPTH], mRegw[0:DEPTH], mLat[0:DEPTH];
  int mRs[NUM_SRC];

  function automatic int rsOf(int s);
    return int'(id_rs[s*AW +: AW]);
  endfunction

  function automatic int mStall();
    for (int s = 0; s < NUM_SRC; s++) begin
      int r = rsOf(s);
      if (id_valid && r != 0) begin
        for (int p = 0; p <= DEPTH; p++) begin
          if (mVld[p] != 0 && mRegw[p] != 0 && mRd[p] == r) begin
            if (mLat[p] > p) return 1;
            break;
          end
        end
      end
    end
    return 0;
  endfunction

  function automatic int mSel(int s);
    if (mVld[0] == 0 || mRs[s] == 0) return 0;
    for (int p = 1; p <= DEPTH; p++)
      if (mVld[p] != 0 && mRegw[p] != 0 && mRd[p] == mRs[s]) return p;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p <= DEPTH; p++) mVld[p] <= 0;
    end else if (!hold) begin
      for (int p = 1; p <= DEPTH; p++) begin
        mVld[p]  <= mVld[p-1];
        mRd[p]   <= mRd[p-1];
        mRegw[p] <= mRegw[p-1];
        mLat[p]  <= mLat[p-1];
      end
      mVld[0]  <= (id_valid && !flush && mStall() == 0) ? 1 : 0;
      mRd[0]   <= int'(id_rd);
      mRegw[0] <= int'(id_regw);
      mLat[0]  <= int'(id_lat);
      for (int s = 0; s < NUM_SRC; s++) mRs[s] <= rsOf(s);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_stall", int'(stall), mStall());
      for (int s = 0; s < NUM_SRC; s++)
        chk($sformatf("model_sel%0d", s), int'(ex_fwd_sel[s*SW +: SW]), mSel(s));
    end
  end

  task automatic drv(bit v, int rs0, int rs1, int rd, bit w, int lat);
    id_valid = v;
    id_rs    = {AW'(rs1), AW'(rs0)};
    id_rd    = AW'(rd);
    id_regw  = w;
    id_lat   = LAT_W'(lat);
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    nop();
    repeat (DEPTH+1) cyc();
  endtask

  // Hand-computed literal expectations.
  task automatic pin(string n, int st, int s0, int s1);
    #1;
    chk({n, "_stall"}, int'(stall), st);
    chk({n, "_sel0"}, int'(ex_fwd_sel[0 +: SW]), s0);
    chk({n, "_sel1"}, int'(ex_fwd_sel[SW +: SW]), s1);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    checking = 1'b1;
    pin("reset", 0, 0, 0);

    // ALU chain: add $3 ; sub $4,$3,$3
    drv(1, 1, 2, 3, 1, 0);   pin("alu_id", 0, 0, 0);
    cyc(); drv(1, 3, 3, 4, 1, 0); pin("alu_dep", 0, 0, 0);
    cyc(); nop();            pin("alu_fwd", 0, 1, 1);
    drain();

    // Load-use: lw $5 ; add $6,$5,$0
    drv(1, 1, 0, 5, 1, 1);   pin("lu_id", 0, 0, 0);
    cyc(); drv(1, 5, 0, 6, 1, 0); pin("lu_stall", 1, 0, 0);
    cyc();                   pin("lu_bubble", 0, 0, 0);
    cyc(); nop();            pin("lu_fwd", 0, 2, 0);
    drain();

    // Shadowing: add $7 ; lw $7 ; or $8,$7,$0
    drv(1, 1, 2, 7, 1, 0);   pin("sh_add", 0, 0, 0);
    cyc(); drv(1, 1, 0, 7, 1, 1); pin("sh_lw", 0, 0, 0);
    cyc(); drv(1, 7, 0, 8, 1, 0); pin("sh_stall", 1, 0, 0);
    cyc();                   pin("sh_bubble", 0, 0, 0);
    cyc(); nop();            pin("sh_fwd", 0, 2, 0);
    drain();

    // Register $0 is never a dependency
    drv(1, 1, 0, 0, 1, 1);   pin("z_lw", 0, 0, 0);
    cyc(); drv(1, 0, 0, 1, 1, 0); pin("z_stall", 0, 0, 0);
    cyc(); nop();            pin("z_fwd", 0, 0, 0);
    drain();

    // Hold during a load-use stall
    drv(1, 1, 0, 9, 1, 1);   pin("hd_lw", 0, 0, 0);
    cyc(); drv(1, 9, 9, 10, 1, 0); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pin($sformatf("hd_frozen%0d", i), 1, 0, 0);
      cyc();
    end
    hold = 1'b0;             pin("hd_release", 1, 0, 0);
    cyc();                   pin("hd_bubble", 0, 0, 0);
    cyc(); nop();            pin("hd_fwd", 0, 2, 2);
    drain();

    // Flush kills the ID->EX transfer
    drv(1, 1, 2, 11, 1, 0);  pin("fl_add", 0, 0, 0);
    cyc(); drv(1, 11, 11, 12, 1, 0); flush = 1'b1; pin("fl_id", 0, 0, 0);
    cyc(); flush = 1'b0; nop(); pin("fl_bubble", 0, 0, 0);
    cyc();                   pin("fl_after", 0, 0, 0);
    drain();

    // Flush coinciding with a stall: stall still reported, one bubble
    drv(1, 1, 0, 17, 1, 1);  pin("fs_lw", 0, 0, 0);
    cyc(); drv(1, 17, 0, 18, 1, 0); flush = 1'b1; pin("fs_stall", 1, 0, 0);
    cyc(); flush = 1'b0;     pin("fs_bubble", 0, 0, 0);
    cyc(); nop();            pin("fs_fwd", 0, 2, 0);
    drain();

    // Latency 2: two stall cycles, then forward from slot 3
    drv(1, 1, 0, 15, 1, 2);  pin("l2_lw", 0, 0, 0);
    cyc(); drv(1, 0, 15, 16, 1, 0); pin("l2_s1", 1, 0, 0);
    cyc();                   pin("l2_s2", 1, 0, 0);
    cyc();                   pin("l2_go", 0, 0, 0);
    cyc(); nop();            pin("l2_fwd", 0, 0, 3);
    drain();

    // Reset mid-pipe clears in-flight producers
    drv(1, 1, 0, 13, 1, 1);  pin("rs_lw", 0, 0, 0);
    cyc(); drv(1, 13, 0, 14, 1, 0); pin("rs_pre", 1, 0, 0);
    rst = 1'b1;
    cyc();                   pin("rs_post", 0, 0, 0);
    rst = 1'b0;
    cyc(); nop();            pin("rs_after", 0, 0, 0);
    drain();

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
